// File: rtl/normalizer.sv
// Normalize / round-to-nearest-even / pack stage producing an IEEE-754 binary32 word.
// Takes a raw sign/exponent/mantissa result from the adder-side datapath and emits z_o plus exception flags.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for data_valid_i; operands captured on the strobe
// NORM  | specials resolved, else one-bit-per-cycle normalize shift
// ROUND | round-to-nearest-even, range check, pack
// DONE  | data_valid_o pulse; z_o and flags hold the new result
module normalizer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_valid_i,
  input  logic        sign_i,
  input  logic [9:0]  exp_i,
  input  logic [26:0] mant_i,
  input  logic        inf_i,
  input  logic        nan_i,
  output logic        data_valid_o,
  output logic        busy_o,
  output logic [31:0] z_o,
  output logic        except_invalid_operation_o,
  output logic        except_overflow_o,
  output logic        except_underflow_o,
  output logic        except_inexact_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               sign_q, inf_q, nan_q;
  // Two extra bits so carry/left-shift adjustments never wrap past -512..511.
  logic signed [11:0] exp_q;
  logic [26:0]        mant_q;

  logic               round_up, rnd_carry;
  logic [24:0]        rnd_sum;
  logic [22:0]        frac_rnd;
  logic signed [11:0] exp_rnd;

  logic [31:0]        z_d;
  logic               inv_d, ovf_d, unf_d, inx_d;

  always_comb begin
    state_d   = state_q;
    z_d       = z_o;
    inv_d     = 1'b0;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    inx_d     = 1'b0;
    round_up  = mant_q[1] & (mant_q[0] | mant_q[2]);
    rnd_sum   = mant_q[26:2] + {24'd0, round_up};
    rnd_carry = rnd_sum[24];
    frac_rnd  = rnd_carry ? rnd_sum[23:1] : rnd_sum[22:0];
    exp_rnd   = exp_q + $signed({11'd0, rnd_carry});

    case (state_q)
      IDLE: begin
        if (data_valid_i) state_d = NORM;
      end
      NORM: begin
        if (nan_q) begin
          z_d     = 32'h7FFF_FFFF;
          inv_d   = 1'b1;
          state_d = DONE;
        end else if (inf_q) begin
          z_d     = {sign_q, 8'hFF, 23'd0};
          state_d = DONE;
        end else if (mant_q == 27'd0) begin
          z_d     = {sign_q, 31'd0};
          state_d = DONE;
        end else if (mant_q[26] || mant_q[25]) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        state_d = DONE;
        inx_d   = mant_q[1] | mant_q[0];
        if (exp_rnd >= 12'sd255) begin
          z_d   = {sign_q, 8'hFF, 23'd0};
          ovf_d = 1'b1;
          inx_d = 1'b1;
        end else if (exp_rnd <= 12'sd0) begin
          z_d   = {sign_q, 31'd0};
          unf_d = 1'b1;
          inx_d = 1'b1;
        end else begin
          z_d = {sign_q, exp_rnd[7:0], frac_rnd};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q                    <= IDLE;
      sign_q                     <= 1'b0;
      inf_q                      <= 1'b0;
      nan_q                      <= 1'b0;
      exp_q                      <= 12'sd0;
      mant_q                     <= 27'd0;
      busy_o                     <= 1'b0;
      data_valid_o               <= 1'b0;
      z_o                        <= 32'd0;
      except_invalid_operation_o <= 1'b0;
      except_overflow_o          <= 1'b0;
      except_underflow_o         <= 1'b0;
      except_inexact_o           <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_o       <= (state_d != IDLE);
      data_valid_o <= (state_d == DONE);
      if (state_d == DONE) begin
        z_o                        <= z_d;
        except_invalid_operation_o <= inv_d;
        except_overflow_o          <= ovf_d;
        except_underflow_o         <= unf_d;
        except_inexact_o           <= inx_d;
      end
      case (state_q)
        IDLE: begin
          if (data_valid_i) begin
            sign_q <= sign_i;
            exp_q  <= {{2{exp_i[9]}}, exp_i};
            mant_q <= mant_i;
            inf_q  <= inf_i;
            nan_q  <= nan_i;
          end
        end
        NORM: begin
          if (!nan_q && !inf_q && (mant_q != 27'd0)) begin
            if (mant_q[26]) begin
              // Old guard drops into the sticky slot; old sticky is folded in.
              mant_q <= {1'b0, mant_q[26:2], mant_q[1] | mant_q[0]};
              exp_q  <= exp_q + 12'sd1;
            end else if (!mant_q[25]) begin
              mant_q <= {mant_q[25:0], 1'b0};
              exp_q  <= exp_q - 12'sd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_normalizer.sv
// Randomized self-checking bench for normalizer against an arithmetic reference model.
// Covers directed boundary cases, specials, handshake ignore and mid-operation reset.
module tb_normalizer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        data_valid_i = 1'b0;
  logic        sign_i = 1'b0;
  logic [9:0]  exp_i = '0;
  logic [26:0] mant_i = '0;
  logic        inf_i = 1'b0;
  logic        nan_i = 1'b0;
  logic        data_valid_o, busy_o;
  logic [31:0] z_o;
  logic        inv_o, ovf_o, unf_o, inx_o;

  int total = 0;
  int bad = 0;

  normalizer dut (
    .clk_i                      (clk_i),
    .rst_i                      (rst_i),
    .data_valid_i               (data_valid_i),
    .sign_i                     (sign_i),
    .exp_i                      (exp_i),
    .mant_i                     (mant_i),
    .inf_i                      (inf_i),
    .nan_i                      (nan_i),
    .data_valid_o               (data_valid_o),
    .busy_o                     (busy_o),
    .z_o                        (z_o),
    .except_invalid_operation_o (inv_o),
    .except_overflow_o          (ovf_o),
    .except_underflow_o         (unf_o),
    .except_inexact_o           (inx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  // Reference: find leading one, normalize in one step, then round and range-check.
  task automatic model(input logic s, input int e_in, input logic [26:0] m_in,
                       input logic inf, input logic nan,
                       output logic [31:0] z, output logic [3:0] fl, output int lat);
    int          e, p, k, q;
    logic [26:0] m;
    logic        g, st, ru;
    e = e_in;
    m = m_in;
    fl = 4'b0000;
    lat = 2;
    if (nan) begin
      z = 32'h7FFF_FFFF;
      fl = 4'b1000;
    end else if (inf) begin
      z = {s, 8'hFF, 23'd0};
    end else if (m == 27'd0) begin
      z = {s, 31'd0};
    end else begin
      p = 26;
      while (!m[p]) p--;
      if (p == 26) begin
        m = (m >> 1) | {26'd0, m_in[0]};
        e = e + 1;
        k = 0;
      end else begin
        k = 25 - p;
        m = m << k;
        e = e - k;
      end
      lat = 3 + k;
      q  = int'(m[26:2]);
      g  = m[1];
      st = m[0];
      ru = g & (st | m[2]);
      q  = q + int'(ru);
      if (q >= (1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
      fl[0] = g | st;
      if (e >= 255) begin
        z = {s, 8'hFF, 23'd0};
        fl = 4'b0101;
      end else if (e <= 0) begin
        z = {s, 31'd0};
        fl = 4'b0011;
      end else begin
        z = {s, e[7:0], q[22:0]};
      end
    end
  endtask

  task automatic run_op(input logic s, input logic [9:0] e, input logic [26:0] m,
                        input logic inf, input logic nan);
    logic [31:0] z_exp;
    logic [3:0]  fl_exp;
    int          lat, cyc;
    logic        got;
    model(s, int'($signed(e)), m, inf, nan, z_exp, fl_exp, lat);
    @(negedge clk_i);
    sign_i = s; exp_i = e; mant_i = m; inf_i = inf; nan_i = nan;
    data_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    data_valid_i = 1'b0;
    chk("busy_start", {31'd0, busy_o}, 32'd1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk_i);
      cyc++;
      #1;
      if (data_valid_o) got = 1'b1;
    end
    chk("no_timeout", {31'd0, got}, 32'd1);
    chk("latency", cyc + 1, lat);
    chk("z", z_o, z_exp);
    chk("flags", {28'd0, inv_o, ovf_o, unf_o, inx_o}, {28'd0, fl_exp});
    @(posedge clk_i);
    #1;
    chk("pulse_end", {30'd0, data_valid_o, busy_o}, 32'd0);
  endtask

  int          cnt;
  logic [26:0] rm;
  logic [9:0]  re;
  int          rp, sel;

  initial begin
    #12;
    chk("rst_z", z_o, 32'd0);
    chk("rst_ctl", {26'd0, data_valid_o, busy_o, inv_o, ovf_o, unf_o, inx_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    run_op(1'b0, 10'd127, 27'h3000000, 1'b0, 1'b0);
    run_op(1'b0, 10'd127, 27'h4000000, 1'b0, 1'b0);
    run_op(1'b0, 10'd254, 27'h4000000, 1'b0, 1'b0);
    run_op(1'b0, 10'd126, 27'h0400000, 1'b0, 1'b0);
    run_op(1'b0, 10'd2,   27'h0400000, 1'b0, 1'b0);
    run_op(1'b0, 10'd127, 27'h3FFFFFE, 1'b0, 1'b0);
    run_op(1'b0, 10'd127, 27'h2000002, 1'b0, 1'b0);
    run_op(1'b0, 10'd127, 27'h2000006, 1'b0, 1'b0);
    run_op(1'b0, 10'd127, 27'h2000000, 1'b1, 1'b1);
    run_op(1'b1, 10'd127, 27'h2000000, 1'b1, 1'b0);
    run_op(1'b1, 10'd127, 27'h0000000, 1'b0, 1'b0);
    run_op(1'b0, 10'd127, 27'h0000001, 1'b0, 1'b0);
    run_op(1'b1, 10'h200, 27'h2000000, 1'b0, 1'b0);
    run_op(1'b0, 10'h1FF, 27'h4000000, 1'b0, 1'b0);

    // Stray strobe while busy must be dropped, not queued.
    @(negedge clk_i);
    sign_i = 1'b0; exp_i = 10'd126; mant_i = 27'h0400000; inf_i = 1'b0; nan_i = 1'b0;
    data_valid_i = 1'b1;
    @(negedge clk_i);
    nan_i = 1'b1;
    @(negedge clk_i);
    data_valid_i = 1'b0;
    nan_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i);
      #1;
      if (data_valid_o) cnt++;
    end
    chk("ignore_count", cnt, 1);
    chk("ignore_z", z_o, 32'h3D80_0000);

    // Reset in the middle of a long shift sequence.
    run_op(1'b0, 10'd127, 27'h3000000, 1'b0, 1'b0);
    @(negedge clk_i);
    exp_i = 10'd127; mant_i = 27'h0000010;
    data_valid_i = 1'b1;
    @(negedge clk_i);
    data_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_z", z_o, 32'd0);
    chk("mid_rst_ctl", {26'd0, data_valid_o, busy_o, inv_o, ovf_o, unf_o, inx_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk_i);
      #1;
      if (data_valid_o) cnt++;
    end
    chk("rst_no_dv", cnt, 0);
    run_op(1'b0, 10'd126, 27'h0400000, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 15);
      rp  = $urandom_range(0, 26);
      rm  = 27'($urandom) & ((27'd1 << rp) - 27'd1);
      rm  = rm | (27'd1 << rp);
      if (sel == 0) rm = 27'd0;
      if ($urandom_range(0, 1) == 0) re = 10'($urandom);
      else re = 10'($urandom_range(0, 300) - 20);
      run_op(1'($urandom), re, rm, sel == 1, sel == 2);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk_i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
